m6502_alu_pipe: RTL and testbench
=================================

M6502_ALU_PIPE -- requirements
Module: m6502_alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter: DECIMAL_EN, default 1, enables BCD mode for ADD/SUB; when 0, the decimal input SHALL be ignored.
REQ-003 Ports SHALL be as follows (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- operation  in  8  opcode.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- carry_in  in  1  carry/borrow input.
- decimal  in  1  BCD mode for ADD/SUB.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- carry, zero, negative, overflow  out  1 each  registered flags.

Function
REQ-004 The opcodes SHALL be: AND 0x01, OR 0x02, XOR 0x03, NOT 0x04, ASL 0x11, ROL 0x12, LSR 0x13, ROR 0x14, ADD 0x21, INC 0x22, SUB 0x23, DEC 0x24, CMP 0x31.
REQ-005 The FSM SHALL have states IDLE, ADJUST and HOLD; in_ready SHALL be 1 only in IDLE while reset_n=1.
REQ-006 Accept occurs when in_valid=1 and in_ready=1; operation, operands, carry_in and decimal SHALL be captured only at accept, and later input changes SHALL be ignored.
REQ-007 Binary operation accepted at edge T: outputs SHALL be loaded at T, the FSM SHALL move IDLE->HOLD, and out_valid SHALL be 1 from T+1.
REQ-008 Decimal ADD/SUB (decimal=1, DECIMAL_EN=1) accepted at T: the FSM SHALL move IDLE->ADJUST, then ADJUST->HOLD at T+1 with the corrected result, and out_valid SHALL be 1 from T+2.
REQ-009 In HOLD, all outputs SHALL remain stable; HOLD->IDLE SHALL occur on the edge where out_ready=1, out_valid SHALL fall next cycle, and there is no same-cycle accept bypass.
REQ-010 Logic ops SHALL produce: AND/OR/XOR = a op b; NOT = ~a; C=0; V=0.
REQ-011 Shifts SHALL produce:
- ASL = {a[W-2:0],0}, C=a[W-1].
- ROL = {a[W-2:0],carry_in}, C=a[W-1].
- LSR = {0,a[W-1:1]}, C=a[0].
- ROR = {carry_in,a[W-1:1]}, C=a[0].
- V=0 for all shifts.
REQ-012 Binary ADD SHALL produce a+b+carry_in (WIDTH+1-bit sum): C=sum[W], V=(a[W-1]==b[W-1])&&(r[W-1]!=a[W-1]).
REQ-013 Binary SUB SHALL produce a+~b+carry_in, with carry_in=1 meaning no borrow: C=carry-out (1=no borrow), V=(a[W-1]!=b[W-1])&&(r[W-1]!=a[W-1]).
REQ-014 INC/DEC SHALL produce a+1 / a-1 modulo 2^WIDTH, with C=0 and V=0.
REQ-015 CMP SHALL produce: result=a unchanged; C=(a>=b unsigned); Z=(a==b); N=(a-b)[W-1]; V=0.
REQ-016 For all other defined ops, Z=(result==0) and N=result[W-1].
REQ-017 Undefined opcodes SHALL be accepted and complete with one-cycle latency, with result=0 and all flags 0.
REQ-018 Decimal ADD SHALL ripple per nibble from LSB: digit=a_n+b_n+c; if digit>9, add 6 and set c=1, else c=0; the final c SHALL drive C.
REQ-019 Decimal SUB SHALL ripple per nibble: d=a_n-b_n-(1-c); if d<0, add 10 and set borrow, c=0; else c=1; the final c SHALL drive C.
REQ-020 Decimal-mode flags: Z and N SHALL come from the corrected result, and V SHALL come from the binary intermediate per REQ-012/013.
REQ-021 Non-BCD digits (>9) SHALL be processed by the same algorithm, with no error indication.
REQ-022 INC, DEC and CMP SHALL ignore decimal.

Reset
REQ-023 While reset_n=0 at a rising edge: state=IDLE, out_valid=0, result=0, carry/zero/negative/overflow=0; in_ready SHALL be 0 while reset_n=0.
REQ-024 Reset in ADJUST or HOLD SHALL discard the in-flight operation with no out_valid pulse, and in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-025 WIDTH=8, binary ADD 0x50+0x50, cin=0 -> result 0x50+0x50=0xA0, C=0, V=1, N=1, Z=0; out_valid at T+1.
REQ-026 WIDTH=8, decimal ADD 0x58+0x46, cin=1 -> result 0x05, C=1; out_valid at T+2, not at T+1.
REQ-027 WIDTH=8 decimal SUB 0x12-0x21 (cin=1) -> result 0x91, C=0; WIDTH=16 decimal ADD 0x9999+0x0001 (cin=0) -> result 0x0000, C=1, Z=1.
REQ-028 CMP 0x40 vs 0x40 -> result 0x40, Z=1, C=1, N=0; ROR 0x01 with cin=1 -> 0x80, C=1, N=1.
REQ-029 out_ready held 0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle, then the second op is accepted.
REQ-030 reset_n=0 for one edge while in ADJUST -> out_valid stays 0, all outputs 0, in_ready=1 after release; opcode 0x7F -> result 0, all flags 0.

Source files
------------

// File: rtl/m6502_alu_pipe_if.sv
// m6502_alu_pipe_if: request/response bundle for the 6502-style ALU pipe.
// Ports (master drives / slave drives):
//   master -> slave: in_valid, operation[7:0], op_a, op_b, carry_in, decimal, out_ready
//   slave -> master: in_ready, out_valid, result, carry, zero, negative, overflow
interface m6502_alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       operation;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic             decimal;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, operation, op_a, op_b, carry_in, decimal, out_ready,
        input  in_ready, out_valid, result, carry, zero, negative, overflow
    );

    modport slave (
        input  in_valid, operation, op_a, op_b, carry_in, decimal, out_ready,
        output in_ready, out_valid, result, carry, zero, negative, overflow
    );
endinterface

// File: rtl/m6502_alu_pipe.sv
// m6502_alu_pipe: 6502-style ALU with valid/ready handshake and a BCD adjust stage.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      m6502_alu_pipe_if.slave (request, operands, registered result and C/Z/N/V)
module m6502_alu_pipe #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input logic             clk,
    input logic             reset_n,
    m6502_alu_pipe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADJUST, HOLD} state_t;

    state_t           r_state, w_next;
    logic [7:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_cin, r_c, r_z, r_n, r_v;
    logic [7:0]       w_op;
    logic [WIDTH-1:0] w_a, w_b, w_bx, w_bcd, w_res;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [5:0]       w_d;
    logic             w_adj, w_accept, w_dec, w_sub, w_cin, w_load;
    logic             w_bcd_c, w_c, w_v, w_z, w_n, w_zn;

    assign bus.in_ready  = reset_n && r_state == IDLE;
    assign bus.out_valid = r_state == HOLD;
    assign bus.result    = r_res;
    assign bus.carry     = r_c;
    assign bus.zero      = r_z;
    assign bus.negative  = r_n;
    assign bus.overflow  = r_v;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_adj    = r_state == ADJUST;
    // The ALU sees live inputs at accept and the captured operands during ADJUST.
    assign w_op     = w_adj ? r_op : bus.operation;
    assign w_a      = w_adj ? r_a : bus.op_a;
    assign w_b      = w_adj ? r_b : bus.op_b;
    assign w_cin    = w_adj ? r_cin : bus.carry_in;
    assign w_sub    = w_op == 8'h23;
    // ADJUST is only ever entered for a decimal ADD/SUB, so it implies BCD mode.
    assign w_dec    = w_adj || (DECIMAL_EN && bus.decimal && (w_op == 8'h21 || w_sub));
    assign w_bx     = w_sub ? ~w_b : w_b;
    assign w_sum    = {1'b0, w_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
    assign w_load   = (w_accept && !w_dec) || w_adj;

    // Nibble-serial BCD ripple; w_d is 6 bits so a negative SUB digit shows in bit 5.
    always_comb begin
        w_bcd   = '0;
        w_bcd_c = w_cin;
        w_d     = '0;
        for (int n = 0; n < WIDTH / 4; n++) begin
            if (w_sub) begin
                w_d     = {2'b00, w_a[4*n +: 4]} - {2'b00, w_b[4*n +: 4]} - {5'b0, ~w_bcd_c};
                w_bcd_c = !w_d[5];
                w_d     = w_d[5] ? w_d + 6'd10 : w_d;
            end else begin
                w_d     = {2'b00, w_a[4*n +: 4]} + {2'b00, w_b[4*n +: 4]} + {5'b0, w_bcd_c};
                w_bcd_c = w_d > 6'd9;
                w_d     = w_bcd_c ? w_d + 6'd6 : w_d;
            end
            w_bcd[4*n +: 4] = w_d[3:0];
        end
    end

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_zn  = 1'b1;
        case (w_op)
            8'h01: w_res = w_a & w_b;
            8'h02: w_res = w_a | w_b;
            8'h03: w_res = w_a ^ w_b;
            8'h04: w_res = ~w_a;
            8'h11: begin w_res = {w_a[WIDTH-2:0], 1'b0};  w_c = w_a[WIDTH-1]; end
            8'h12: begin w_res = {w_a[WIDTH-2:0], w_cin}; w_c = w_a[WIDTH-1]; end
            8'h13: begin w_res = {1'b0, w_a[WIDTH-1:1]};  w_c = w_a[0]; end
            8'h14: begin w_res = {w_cin, w_a[WIDTH-1:1]}; w_c = w_a[0]; end
            8'h21, 8'h23: begin
                w_res = w_dec ? w_bcd : w_sum[WIDTH-1:0];
                w_c   = w_dec ? w_bcd_c : w_sum[WIDTH];
                // Overflow always comes from the binary sum, even in BCD mode.
                w_v   = (w_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            8'h22: w_res = w_a + 1'b1;
            8'h24: w_res = w_a - 1'b1;
            8'h31: begin w_res = w_a; w_c = !w_diff[WIDTH]; end
            default: w_zn = 1'b0;
        endcase
        w_z = w_op == 8'h31 ? w_a == w_b : w_zn && w_res == '0;
        w_n = w_op == 8'h31 ? w_diff[WIDTH-1] : w_zn && w_res[WIDTH-1];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_dec ? ADJUST : HOLD) : IDLE;
            ADJUST:  w_next = HOLD;
            HOLD:    w_next = bus.out_ready ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_res <= w_res;
                r_c   <= w_c;
                r_z   <= w_z;
                r_n   <= w_n;
                r_v   <= w_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= bus.operation;
            r_a   <= bus.op_a;
            r_b   <= bus.op_b;
            r_cin <= bus.carry_in;
        end
    end
endmodule

// File: tb/tb_m6502_alu_pipe.sv
// tb_m6502_alu_pipe: directed checks of the ALU pipe at WIDTH=8 and WIDTH=16.
module tb_m6502_alu_pipe;
    logic clk;
    logic reset_n;
    int   total;
    int   passed;

    m6502_alu_pipe_if #(.WIDTH(8))  b8 ();
    m6502_alu_pipe_if #(.WIDTH(16)) b16 ();

    m6502_alu_pipe #(.WIDTH(8))  u8  (.clk(clk), .reset_n(reset_n), .bus(b8));
    m6502_alu_pipe #(.WIDTH(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic out8(input string tag, input logic ov, input logic [7:0] r,
                        input logic c, input logic z, input logic n, input logic v);
        chk({tag, "_valid"}, 32'(b8.out_valid), 32'(ov));
        chk({tag, "_result"}, 32'(b8.result), 32'(r));
        chk({tag, "_c"}, 32'(b8.carry), 32'(c));
        chk({tag, "_z"}, 32'(b8.zero), 32'(z));
        chk({tag, "_n"}, 32'(b8.negative), 32'(n));
        chk({tag, "_v"}, 32'(b8.overflow), 32'(v));
    endtask

    task automatic go8(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic dec);
        b8.operation = op;
        b8.op_a      = a;
        b8.op_b      = b;
        b8.carry_in  = cin;
        b8.decimal   = dec;
        b8.in_valid  = 1'b1;
        step();
        b8.in_valid  = 1'b0;
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset_n = 1'b0;
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        b8.operation = '0;
        b8.op_a = '0;
        b8.op_b = '0;
        b8.carry_in = 1'b0;
        b8.decimal = 1'b0;
        b16.in_valid = 1'b0;
        b16.out_ready = 1'b1;
        b16.operation = '0;
        b16.op_a = '0;
        b16.op_b = '0;
        b16.carry_in = 1'b0;
        b16.decimal = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(b8.in_ready), 32'd0);
        out8("rst", 0, 8'h00, 0, 0, 0, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(b8.in_ready), 32'd1);

        go8(8'h21, 8'h50, 8'h50, 0, 0);
        out8("add_bin", 1, 8'hA0, 0, 0, 1, 1);
        chk("add_busy_ready", 32'(b8.in_ready), 32'd0);
        step();
        chk("add_done_valid", 32'(b8.out_valid), 32'd0);
        chk("add_done_ready", 32'(b8.in_ready), 32'd1);

        go8(8'h21, 8'h58, 8'h46, 1, 1);
        b8.op_a = 8'hFF;
        b8.decimal = 1'b0;
        chk("dadd_t1_valid", 32'(b8.out_valid), 32'd0);
        step();
        out8("dadd", 1, 8'h05, 1, 0, 0, 1);
        step();

        go8(8'h23, 8'h12, 8'h21, 1, 1);
        chk("dsub_t1_valid", 32'(b8.out_valid), 32'd0);
        step();
        out8("dsub", 1, 8'h91, 0, 0, 1, 0);
        step();

        go8(8'h31, 8'h40, 8'h40, 0, 0);
        out8("cmp", 1, 8'h40, 1, 1, 0, 0);
        step();
        go8(8'h14, 8'h01, 8'h00, 1, 0);
        out8("ror", 1, 8'h80, 1, 0, 1, 0);
        step();
        go8(8'h22, 8'h09, 8'h00, 0, 1);
        out8("inc_dec_ignored", 1, 8'h0A, 0, 0, 0, 0);
        step();
        go8(8'h11, 8'h81, 8'h00, 1, 0);
        out8("asl", 1, 8'h02, 1, 0, 0, 0);
        step();
        go8(8'h13, 8'h01, 8'h00, 0, 0);
        out8("lsr", 1, 8'h00, 1, 1, 0, 0);
        step();
        go8(8'h23, 8'h10, 8'h01, 1, 0);
        out8("sub_bin", 1, 8'h0F, 1, 0, 0, 0);
        step();

        b8.out_ready = 1'b0;
        go8(8'h01, 8'hF0, 8'h3C, 0, 0);
        b8.operation = 8'h02;
        b8.op_a = 8'h0F;
        b8.op_b = 8'hF0;
        b8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out8("hold", 1, 8'h30, 0, 0, 0, 0);
            chk("hold_ready", 32'(b8.in_ready), 32'd0);
            step();
        end
        b8.out_ready = 1'b1;
        step();
        chk("release_valid", 32'(b8.out_valid), 32'd0);
        chk("release_ready", 32'(b8.in_ready), 32'd1);
        step();
        b8.in_valid = 1'b0;
        out8("second_or", 1, 8'hFF, 0, 0, 1, 0);
        step();

        go8(8'h7F, 8'hFF, 8'hFF, 1, 1);
        out8("undef", 1, 8'h00, 0, 0, 0, 0);
        step();
        go8(8'h24, 8'h00, 8'h00, 0, 0);
        out8("dec", 1, 8'hFF, 0, 0, 1, 0);
        step();

        go8(8'h21, 8'h11, 8'h22, 0, 1);
        chk("adj_valid", 32'(b8.out_valid), 32'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        out8("rst_adj", 0, 8'h00, 0, 0, 0, 0);
        chk("rst_adj_ready", 32'(b8.in_ready), 32'd1);
        step();
        chk("rst_adj_no_pulse", 32'(b8.out_valid), 32'd0);

        b16.operation = 8'h21;
        b16.op_a = 16'h9999;
        b16.op_b = 16'h0001;
        b16.carry_in = 1'b0;
        b16.decimal = 1'b1;
        b16.in_valid = 1'b1;
        step();
        b16.in_valid = 1'b0;
        chk("w16_t1_valid", 32'(b16.out_valid), 32'd0);
        step();
        chk("w16_valid", 32'(b16.out_valid), 32'd1);
        chk("w16_result", 32'(b16.result), 32'h0000);
        chk("w16_c", 32'(b16.carry), 32'd1);
        chk("w16_z", 32'(b16.zero), 32'd1);
        chk("w16_n", 32'(b16.negative), 32'd0);
        chk("w16_v", 32'(b16.overflow), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
